dmem_bridge: RTL and testbench

Data-memory bridge between the core's single-cycle dmem port (req/we/addr/wd/mask/rd/wait) and a backing memory bus with a valid/ready request channel and a separate read-response channel. It sits directly downstream of the core's data-memory interface. It converts the core's stall-based protocol into a multi-cycle bus transaction, holding `dmem_wait` high until the access completes. A watchdog bounds every transaction and reports a sticky bus error.

---
 rtl/dmem_bridge_pkg.sv | 29 ++
 rtl/dmem_bridge_if.sv | 48 ++++
 rtl/dmem_bridge_wdog_counter.sv | 40 ++++
 rtl/dmem_bridge.sv | 165 ++++++++++++++++
 tb/tb_dmem_bridge.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg
//   Shared types and constants for the data-memory bridge.
//   - dbstate_e : bridge FSM states
//   - dbreq_t   : core request captured at the start of a transaction
//   - DEFAULT_ERR_DATA : read data substituted when a bus phase times out
//   - wordAlign : forces a byte address onto its containing 32-bit word
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAITR = 2'd2,
    DONE  = 2'd3
  } dbstate_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  mask;
  } dbreq_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  function automatic logic [31:0] wordAlign(input logic [31:0] byteAddr);
    return {byteAddr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if
//   Two signal bundles used by the bridge:
//   dmem_core_if : the core's single-cycle, stall-based data-memory port.
//     master = core (drives req/we/addr/wd/mask), slave = bridge (drives rd/wait).
//   mem_bus_if   : the backing memory bus, a valid/ready request channel plus
//     a separate read-response channel.
//     master = bridge (drives valid/we/addr/wdata/be), slave = memory
//     (drives ready/rvalid/rdata).
interface dmem_core_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wd;
  logic [3:0]  dmem_mask;
  logic [31:0] dmem_rd;
  logic        dmem_wait;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wd, dmem_mask,
    input  dmem_rd, dmem_wait
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wd, dmem_mask,
    output dmem_rd, dmem_wait
  );
endinterface

interface mem_bus_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dmem_bridge_wdog_counter.sv
// wdog_counter
//   Bounds a single bus phase of the bridge. The count restarts whenever the
//   bridge changes state and advances once per cycle while enabled. o_expired
//   flags the last permitted cycle of the phase (count == TIMEOUT-1).
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous, active-low reset
//   i_clr     : restart the count (bridge is entering a new state)
//   i_en      : bridge is in a bounded phase (ISSUE or WAITR)
//   o_expired : the current cycle is the final one allowed for this phase
module wdog_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // The count saturates at LAST; the bridge always leaves the phase in that
  // cycle, so the saturation only guards against wrap-around.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_en && (r_count == LAST);

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge
//   Converts the core's stall-based data-memory port into a multi-cycle
//   transaction on a valid/ready memory bus with a separate read-response
//   channel. The core is stalled (dmem_wait) until the access finishes; a
//   watchdog bounds each bus phase and records a sticky bus error.
// Parameters:
//   TIMEOUT  : cycles allowed in ISSUE or WAITR before abort (>= 2)
//   ERR_DATA : read data returned when a read times out
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous, active-low reset
//   core      : dmem_core_if.slave, core request in, rd/wait out
//   bus       : mem_bus_if.master, bus request out, ready/response in
//   o_bus_err : sticky timeout flag, cleared only by reset
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic        clk,
  input  logic        reset,
  dmem_core_if.slave  core,
  mem_bus_if.master   bus,
  output logic        o_bus_err
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAITR = WAITR;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]  r_state;
  logic [1:0]  w_stateNext;
  dbreq_t      r_req;
  logic [31:0] r_rdData;
  logic        r_busErr;

  logic w_wdogEn;
  logic w_wdogClr;
  logic w_expired;
  logic w_timeout;
  logic w_rspAccept;
  logic w_nullWrite;

  // A write with no byte enabled has nothing to do on the bus.
  assign w_nullWrite = core.dmem_we && (core.dmem_mask == 4'b0000);

  // Only a response arriving while we are actually waiting for one counts;
  // late responses after a timeout or a reset are silently dropped.
  assign w_rspAccept = (r_state == ST_WAITR) && bus.mem_rvalid;

  // Next-state logic. In both bus phases the handshake is tested before the
  // watchdog so a handshake in the expiry cycle completes normally.
  always_comb begin
    w_stateNext = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (core.dmem_req) begin
          w_stateNext = w_nullWrite ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_ready) begin
          w_stateNext = r_req.we ? ST_DONE : ST_WAITR;
        end else if (w_expired) begin
          w_stateNext = ST_DONE;
          w_timeout   = 1'b1;
        end
      end
      ST_WAITR: begin
        if (bus.mem_rvalid) begin
          w_stateNext = ST_DONE;
        end else if (w_expired) begin
          w_stateNext = ST_DONE;
          w_timeout   = 1'b1;
        end
      end
      ST_DONE: begin
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Watchdog restarts on every state change so each phase gets its own budget.
  assign w_wdogEn  = (r_state == ST_ISSUE) || (r_state == ST_WAITR);
  assign w_wdogClr = (w_stateNext != r_state);

  wdog_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_wdogClr),
    .i_en      (w_wdogEn),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Request capture. The address is stored word-aligned since only the bus
  // side ever sees it; the fields then stay stable for the whole transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req <= '0;
    end else if ((r_state == ST_IDLE) && core.dmem_req) begin
      r_req <= {core.dmem_we, wordAlign(core.dmem_addr), core.dmem_wd, core.dmem_mask};
    end
  end

  // Read register: filled by a real response, or by ERR_DATA when a read is
  // aborted. A timed-out write leaves it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdData <= '0;
    end else if (w_rspAccept) begin
      r_rdData <= bus.mem_rdata;
    end else if (w_timeout && !r_req.we) begin
      r_rdData <= ERR_DATA;
    end
  end

  // Sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busErr <= 1'b0;
    end else if (w_timeout) begin
      r_busErr <= 1'b1;
    end
  end

  // Core-side stall: in IDLE it follows the request combinationally so the
  // core stalls in the very cycle it asks; DONE releases it for one cycle.
  always_comb begin
    core.dmem_wait = 1'b1;
    case (r_state)
      ST_IDLE:  core.dmem_wait = core.dmem_req;
      ST_DONE:  core.dmem_wait = 1'b0;
      default:  core.dmem_wait = 1'b1;
    endcase
  end

  assign core.dmem_rd  = r_rdData;

  // mem_valid is decoded from state so an asynchronous reset drops it at once.
  assign bus.mem_valid = (r_state == ST_ISSUE);
  assign bus.mem_we    = r_req.we;
  assign bus.mem_addr  = r_req.addr;
  assign bus.mem_wdata = r_req.wd;
  assign bus.mem_be    = r_req.mask;

  assign o_bus_err     = r_busErr;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge
//   Self-checking bench for dmem_bridge with TIMEOUT = 8. A table of directed
//   transactions and a run of random back-to-back accesses drive the core
//   port while a small memory model answers on the bus with per-transaction
//   ready/response latencies. Expected read data is queued when a request is
//   issued and compared when the core retires it.
module tb_dmem_bridge;
  import dmem_bridge_pkg::*;

  localparam int          TB_TIMEOUT = 8;
  localparam logic [31:0] TB_ERR     = 32'hDEAD_BEEF;
  localparam int          NEVER      = 1000;
  localparam int          BUDGET     = 100;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  mask;
    int          readyLat;
    int          rvLat;
    logic [31:0] rdata;
    int          expWait;
    logic [31:0] expRd;
    logic        expErr;
  } vec_t;

  typedef struct packed {
    logic        isRead;
    logic [31:0] rd;
  } sb_t;

  logic clk;
  logic reset;
  logic busErr;

  dmem_core_if coreIf();
  mem_bus_if   busIf();

  int   checkCount = 0;
  int   failCount  = 0;
  sb_t  sbQ[$];
  vec_t vecs[8];
  vec_t rv;
  logic [31:0] lastRd;

  dmem_bridge #(
    .TIMEOUT  (TB_TIMEOUT),
    .ERR_DATA (TB_ERR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .core      (coreIf.slave),
    .bus       (busIf.master),
    .o_bus_err (busErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so a stuck run still ends with a message.
  initial begin
    #100000;
    $display("[TB] FAIL globalTimeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string what, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", what, actual, expected);
    end
  endtask

  // Drives one core request starting just after a falling edge, plays the
  // memory side cycle by cycle, and checks the retire cycle. Returns just
  // after the falling edge that follows the retire edge.
  task automatic applyStimulus(input vec_t v, input string tag);
    int  waitCnt;
    int  readyCnt;
    int  rvCnt;
    bit  accepted;
    bit  done;
    bit  sawValid;
    bit  hs;
    bit  validNow;
    sb_t exp;
    waitCnt  = 0;
    readyCnt = 0;
    rvCnt    = 0;
    accepted = 1'b0;
    done     = 1'b0;
    sawValid = 1'b0;
    coreIf.dmem_req  = 1'b1;
    coreIf.dmem_we   = v.we;
    coreIf.dmem_addr = v.addr;
    coreIf.dmem_wd   = v.wd;
    coreIf.dmem_mask = v.mask;
    sbQ.push_back({~v.we, v.expRd});
    for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
      busIf.mem_ready  = 1'b0;
      busIf.mem_rvalid = 1'b0;
      busIf.mem_rdata  = ~v.rdata;
      #1;
      validNow = busIf.mem_valid;
      if (validNow) begin
        sawValid = 1'b1;
        if (readyCnt >= v.readyLat) busIf.mem_ready = 1'b1;
      end
      if (accepted && !v.we && rvCnt == v.rvLat) begin
        busIf.mem_rvalid = 1'b1;
        busIf.mem_rdata  = v.rdata;
      end
      #1;
      if (!coreIf.dmem_wait) begin
        done = 1'b1;
        checkOutput($sformatf("%s waitCycles", tag), waitCnt, v.expWait);
        if (sbQ.size() == 0) begin
          checkCount++;
          failCount++;
          $display("[TB] FAIL %s scoreboard: got empty queue, expected one entry", tag);
        end else begin
          exp = sbQ.pop_front();
          checkOutput($sformatf("%s dmem_rd(read=%0d)", tag, exp.isRead), coreIf.dmem_rd, exp.rd);
        end
        checkOutput($sformatf("%s bus_err", tag), 32'(busErr), 32'(v.expErr));
      end else begin
        waitCnt++;
        if (validNow) begin
          checkOutput($sformatf("%s mem_addr", tag), busIf.mem_addr, v.addr & 32'hFFFF_FFFC);
          checkOutput($sformatf("%s mem_be", tag), 32'(busIf.mem_be), 32'(v.mask));
          checkOutput($sformatf("%s mem_we", tag), 32'(busIf.mem_we), 32'(v.we));
          if (v.we) checkOutput($sformatf("%s mem_wdata", tag), busIf.mem_wdata, v.wd);
        end
      end
      hs = validNow && busIf.mem_ready;
      @(posedge clk);
      if (accepted) rvCnt++;
      if (hs) accepted = 1'b1;
      else if (validNow) readyCnt++;
      @(negedge clk);
    end
    if (!done) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL %s cycleBudget: no retire within %0d cycles, expected retire after %0d", tag, BUDGET, v.expWait);
    end
    if (v.we && v.mask == 4'b0000) begin
      checkOutput($sformatf("%s nullWriteNoBus", tag), 32'(sawValid), 32'd0);
    end
    coreIf.dmem_req  = 1'b0;
    busIf.mem_ready  = 1'b0;
    busIf.mem_rvalid = 1'b0;
  endtask

  initial begin
    // Directed table (TIMEOUT = 8). expWait counts stall cycles before the
    // retire cycle; expRd is the read register seen in the retire cycle.
    vecs[0] = '{1'b0, 32'h0000_1004, 32'h0, 4'hF, 0, 0, 32'h1234_5678, 3, 32'h1234_5678, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_2006, 32'hAABB_CCDD, 4'b1100, 3, 0, 32'h0, 5, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_3000, 32'h5555_5555, 4'b0000, 0, 0, 32'h0, 1, 32'h1234_5678, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_4008, 32'h0, 4'hF, 2, 4, 32'hCAFE_F00D, 9, 32'hCAFE_F00D, 1'b0};
    // response lands in the watchdog's final cycle: handshake wins
    vecs[4] = '{1'b0, 32'h0000_500C, 32'h0, 4'b0011, 0, 7, 32'h0BAD_C0DE, 10, 32'h0BAD_C0DE, 1'b0};
    // ready lands in the watchdog's final ISSUE cycle: handshake wins
    vecs[5] = '{1'b1, 32'h0000_6000, 32'h0102_0304, 4'hF, 7, 0, 32'h0, 9, 32'h0BAD_C0DE, 1'b0};
    // write never accepted: abort, read register untouched
    vecs[6] = '{1'b1, 32'h0000_7000, 32'h0, 4'b0001, NEVER, 0, 32'h0, 9, 32'h0BAD_C0DE, 1'b1};
    // read never answered: abort with error data
    vecs[7] = '{1'b0, 32'h0000_8000, 32'h0, 4'hF, 0, NEVER, 32'h0, 10, TB_ERR, 1'b1};

    reset            = 1'b0;
    coreIf.dmem_req  = 1'b0;
    coreIf.dmem_we   = 1'b0;
    coreIf.dmem_addr = '0;
    coreIf.dmem_wd   = '0;
    coreIf.dmem_mask = '0;
    busIf.mem_ready  = 1'b0;
    busIf.mem_rvalid = 1'b0;
    busIf.mem_rdata  = '0;

    // Reset state.
    #2;
    checkOutput("reset mem_valid", 32'(busIf.mem_valid), 32'd0);
    checkOutput("reset mem_we", 32'(busIf.mem_we), 32'd0);
    checkOutput("reset mem_addr", busIf.mem_addr, 32'd0);
    checkOutput("reset mem_wdata", busIf.mem_wdata, 32'd0);
    checkOutput("reset mem_be", 32'(busIf.mem_be), 32'd0);
    checkOutput("reset dmem_rd", coreIf.dmem_rd, 32'd0);
    checkOutput("reset bus_err", 32'(busErr), 32'd0);
    checkOutput("reset wait(req=0)", 32'(coreIf.dmem_wait), 32'd0);
    coreIf.dmem_req = 1'b1;
    #1;
    checkOutput("reset wait(req=1)", 32'(coreIf.dmem_wait), 32'd1);
    coreIf.dmem_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // A response arriving after the read timed out must not touch anything.
    busIf.mem_rvalid = 1'b1;
    busIf.mem_rdata  = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    busIf.mem_rvalid = 1'b0;
    #1;
    checkOutput("lateRsp dmem_rd", coreIf.dmem_rd, TB_ERR);
    checkOutput("lateRsp dmem_wait", 32'(coreIf.dmem_wait), 32'd0);
    checkOutput("lateRsp mem_valid", 32'(busIf.mem_valid), 32'd0);
    checkOutput("lateRsp bus_err", 32'(busErr), 32'd1);
    @(negedge clk);

    // Error flag stays set across a clean transaction.
    rv = '{1'b0, 32'h0000_9000, 32'h0, 4'hF, 1, 1, 32'h1357_9BDF, 5, 32'h1357_9BDF, 1'b1};
    applyStimulus(rv, "stickyRead");

    // Reset in the middle of WAITR.
    coreIf.dmem_req  = 1'b1;
    coreIf.dmem_we   = 1'b0;
    coreIf.dmem_addr = 32'h0000_5000;
    coreIf.dmem_mask = 4'hF;
    busIf.mem_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("midReset issue mem_valid", 32'(busIf.mem_valid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    busIf.mem_ready = 1'b0;
    #1;
    checkOutput("midReset waitr mem_valid", 32'(busIf.mem_valid), 32'd0);
    checkOutput("midReset waitr dmem_wait", 32'(coreIf.dmem_wait), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("midReset mem_valid", 32'(busIf.mem_valid), 32'd0);
    checkOutput("midReset bus_err", 32'(busErr), 32'd0);
    checkOutput("midReset dmem_rd", coreIf.dmem_rd, 32'd0);
    checkOutput("midReset mem_addr", busIf.mem_addr, 32'd0);
    checkOutput("midReset wait(req=1)", 32'(coreIf.dmem_wait), 32'd1);
    coreIf.dmem_req = 1'b0;
    #1;
    checkOutput("midReset wait(req=0)", 32'(coreIf.dmem_wait), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rv = '{1'b0, 32'h0000_A000, 32'h0, 4'hF, 0, 2, 32'h2468_ACE0, 5, 32'h2468_ACE0, 1'b0};
    applyStimulus(rv, "postReset");
    lastRd = 32'h2468_ACE0;

    // Back-to-back alternating reads and writes with random latencies.
    for (int i = 0; i < 10; i++) begin
      rv.we       = (i % 2) == 1;
      rv.addr     = $urandom;
      rv.wd       = $urandom;
      rv.mask     = rv.we ? 4'($urandom_range(1, 15)) : 4'hF;
      rv.readyLat = int'($urandom_range(0, 5));
      rv.rvLat    = int'($urandom_range(0, 5));
      rv.rdata    = $urandom;
      rv.expWait  = rv.we ? (2 + rv.readyLat) : (3 + rv.readyLat + rv.rvLat);
      rv.expRd    = rv.we ? lastRd : rv.rdata;
      rv.expErr   = 1'b0;
      lastRd      = rv.expRd;
      applyStimulus(rv, $sformatf("b2b%0d", i));
    end

    checkOutput("scoreboard drained", sbQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
